adc_trigger_front: RTL and testbench

Dual-channel 8-bit ADC capture front end with decimation and level trigger with hysteresis. It generates the ADC conversion clock and emits a 16-bit {ch2,ch1} sample stream with a valid strobe. It sits directly upstream of the SDRAM recorder and replaces free-running start/stop recording with armed, triggered, length-bounded captures. The host control block drives the arm, abort and force inputs.

---
 rtl/adc_front_pkg.sv | 18 +
 rtl/adc_trig_cmp.sv | 51 +++++
 rtl/adc_trigger_front.sv | 204 ++++++++++++++++++++
 tb/tb_adc_trigger_front.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_front_pkg.sv
// Shared definitions for the dual-channel ADC trigger front end:
// capture state encoding, default widths and trigger edge constants.
package adc_front_pkg;

    localparam int DECIM_W_DEF = 8;
    localparam int LEN_W_DEF   = 24;

    localparam logic TRIG_RISING  = 1'b0;
    localparam logic TRIG_FALLING = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRIME   = 2'd1,
        ST_ARMED   = 2'd2,
        ST_CAPTURE = 2'd3
    } front_state_t;

endpackage

// File: rtl/adc_trig_cmp.sv
// Level trigger comparator: registers the saturated prime thresholds derived
// from the latched level/hysteresis and flags prime and trigger conditions.
module adc_trig_cmp
    import adc_front_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] sel,
    input  logic [7:0] level,
    input  logic [7:0] hyst,
    input  logic       trig_edge,
    output logic       prime_hit,
    output logic       trig_hit
);

    logic [8:0] lo_diff;
    logic [8:0] hi_sum;
    logic [7:0] lo_d, lo_q;
    logic [7:0] hi_d, hi_q;

    // 9-bit arithmetic so the borrow/carry selects the saturated value.
    always_comb begin
        lo_diff = {1'b0, level} - {1'b0, hyst};
        hi_sum  = {1'b0, level} + {1'b0, hyst};
        lo_d    = lo_diff[8] ? 8'h00 : lo_diff[7:0];
        hi_d    = hi_sum[8]  ? 8'hFF : hi_sum[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lo_q <= 8'h00;
            hi_q <= 8'hFF;
        end else begin
            lo_q <= lo_d;
            hi_q <= hi_d;
        end
    end

    always_comb begin
        prime_hit = 1'b0;
        trig_hit  = 1'b0;
        if (trig_edge == TRIG_FALLING) begin
            prime_hit = (sel > hi_q);
            trig_hit  = (sel <= level);
        end else begin
            prime_hit = (sel < lo_q);
            trig_hit  = (sel >= level);
        end
    end

endmodule

// File: rtl/adc_trigger_front.sv
// Dual-channel ADC capture front end: conversion clock, decimation, armed
// level trigger with hysteresis and length-bounded sample stream.
module adc_trigger_front
    import adc_front_pkg::*;
#(
    parameter int DECIM_W = DECIM_W_DEF,
    parameter int LEN_W   = LEN_W_DEF
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic [7:0]         adc_in1,
    input  logic [7:0]         adc_in2,
    output logic               adc_clk,
    input  logic               arm,
    input  logic               abort,
    input  logic               force_trig,
    input  logic               trig_src,
    input  logic               trig_edge,
    input  logic [7:0]         trig_level,
    input  logic [7:0]         trig_hyst,
    input  logic [DECIM_W-1:0] decim,
    input  logic [LEN_W-1:0]   capture_len,
    output logic [15:0]        sample_data,
    output logic               sample_valid,
    output logic               triggered,
    output logic               done,
    output logic [1:0]         state,
    output logic [LEN_W-1:0]   sample_count
);

    logic               adc_clk_d, adc_clk_q;
    logic [15:0]        cap_data_d, cap_data_q;
    logic               cap_kept_d, cap_kept_q;
    logic [DECIM_W-1:0] dec_cnt_d, dec_cnt_q;
    front_state_t       state_d, state_q;
    logic               src_d, src_q;
    logic               edge_d, edge_q;
    logic [7:0]         level_d, level_q;
    logic [7:0]         hyst_d, hyst_q;
    logic [DECIM_W-1:0] decim_d, decim_q;
    logic [LEN_W-1:0]   len_d, len_q;
    logic               force_pend_d, force_pend_q;
    logic [LEN_W-1:0]   count_d, count_q;
    logic [15:0]        sample_data_d, sample_data_q;
    logic               sample_valid_d, sample_valid_q;
    logic               triggered_d, triggered_q;
    logic               done_d, done_q;
    logic               fire;
    logic [7:0]         sel;
    logic               prime_hit, trig_hit;

    assign sel = src_q ? cap_data_q[15:8] : cap_data_q[7:0];

    adc_trig_cmp u_cmp (
        .clk       (sys_clk),
        .rst       (sys_rst),
        .sel       (sel),
        .level     (level_q),
        .hyst      (hyst_q),
        .trig_edge (edge_q),
        .prime_hit (prime_hit),
        .trig_hit  (trig_hit)
    );

    always_comb begin
        adc_clk_d      = ~adc_clk_q;
        cap_data_d     = cap_data_q;
        cap_kept_d     = 1'b0;
        dec_cnt_d      = dec_cnt_q;
        state_d        = state_q;
        src_d          = src_q;
        edge_d         = edge_q;
        level_d        = level_q;
        hyst_d         = hyst_q;
        decim_d        = decim_q;
        len_d          = len_q;
        force_pend_d   = force_pend_q;
        count_d        = count_q;
        sample_data_d  = sample_data_q;
        sample_valid_d = 1'b0;
        triggered_d    = 1'b0;
        done_d         = 1'b0;
        fire           = 1'b0;

        if (adc_clk_q) begin
            cap_data_d = {adc_in2, adc_in1};
        end

        // Abort wins over everything; clearing cap_kept flushes the pipeline.
        if (abort) begin
            state_d      = ST_IDLE;
            force_pend_d = 1'b0;
        end else begin
            if (done_q) begin
                state_d = ST_IDLE;
            end
            if (force_trig && (state_q == ST_PRIME || state_q == ST_ARMED)) begin
                force_pend_d = 1'b1;
            end
            if (adc_clk_q && state_q != ST_IDLE) begin
                if (dec_cnt_q == '0) begin
                    cap_kept_d = 1'b1;
                    dec_cnt_d  = decim_q;
                end else begin
                    dec_cnt_d = dec_cnt_q - DECIM_W'(1);
                end
            end
            if (cap_kept_q) begin
                case (state_q)
                    ST_PRIME: begin
                        if (force_trig || force_pend_q) begin
                            fire = 1'b1;
                        end else if (prime_hit) begin
                            state_d = ST_ARMED;
                        end
                    end
                    ST_ARMED: begin
                        if (force_trig || force_pend_q || trig_hit) begin
                            fire = 1'b1;
                        end
                    end
                    ST_CAPTURE: begin
                        sample_valid_d = 1'b1;
                        count_d        = count_q + LEN_W'(1);
                    end
                    default: ;
                endcase
            end
            if (fire) begin
                state_d        = ST_CAPTURE;
                force_pend_d   = 1'b0;
                sample_valid_d = 1'b1;
                triggered_d    = 1'b1;
                count_d        = LEN_W'(1);
            end
            // Zero length means continuous capture, so it never completes.
            if (sample_valid_d) begin
                sample_data_d = cap_data_q;
                done_d        = (len_q != '0) && (count_d == len_q);
            end
            if (arm && state_q == ST_IDLE) begin
                src_d        = trig_src;
                edge_d       = trig_edge;
                level_d      = trig_level;
                hyst_d       = trig_hyst;
                decim_d      = decim;
                len_d        = capture_len;
                dec_cnt_d    = '0;
                count_d      = '0;
                force_pend_d = 1'b0;
                state_d      = ST_PRIME;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            adc_clk_q      <= 1'b0;
            cap_data_q     <= '0;
            cap_kept_q     <= 1'b0;
            dec_cnt_q      <= '0;
            state_q        <= ST_IDLE;
            src_q          <= 1'b0;
            edge_q         <= 1'b0;
            level_q        <= '0;
            hyst_q         <= '0;
            decim_q        <= '0;
            len_q          <= '0;
            force_pend_q   <= 1'b0;
            count_q        <= '0;
            sample_data_q  <= '0;
            sample_valid_q <= 1'b0;
            triggered_q    <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            adc_clk_q      <= adc_clk_d;
            cap_data_q     <= cap_data_d;
            cap_kept_q     <= cap_kept_d;
            dec_cnt_q      <= dec_cnt_d;
            state_q        <= state_d;
            src_q          <= src_d;
            edge_q         <= edge_d;
            level_q        <= level_d;
            hyst_q         <= hyst_d;
            decim_q        <= decim_d;
            len_q          <= len_d;
            force_pend_q   <= force_pend_d;
            count_q        <= count_d;
            sample_data_q  <= sample_data_d;
            sample_valid_q <= sample_valid_d;
            triggered_q    <= triggered_d;
            done_q         <= done_d;
        end
    end

    assign adc_clk      = adc_clk_q;
    assign sample_data  = sample_data_q;
    assign sample_valid = sample_valid_q;
    assign triggered    = triggered_q;
    assign done         = done_q;
    assign state        = state_q;
    assign sample_count = count_q;

endmodule

// File: tb/tb_adc_trigger_front.sv
// Self-checking bench for adc_trigger_front: directed scenarios plus random
// captures compared against a sample-level reference model.
module tb_adc_trigger_front;

    localparam int DECIM_W = 8;
    localparam int LEN_W   = 24;

    logic               sys_clk = 1'b0;
    logic               sys_rst;
    logic [7:0]         adc_in1, adc_in2;
    logic               adc_clk;
    logic               arm, abort, force_trig;
    logic               trig_src, trig_edge;
    logic [7:0]         trig_level, trig_hyst;
    logic [DECIM_W-1:0] decim;
    logic [LEN_W-1:0]   capture_len;
    logic [15:0]        sample_data;
    logic               sample_valid, triggered, done;
    logic [1:0]         state;
    logic [LEN_W-1:0]   sample_count;

    adc_trigger_front #(.DECIM_W(DECIM_W), .LEN_W(LEN_W)) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .adc_in1      (adc_in1),
        .adc_in2      (adc_in2),
        .adc_clk      (adc_clk),
        .arm          (arm),
        .abort        (abort),
        .force_trig   (force_trig),
        .trig_src     (trig_src),
        .trig_edge    (trig_edge),
        .trig_level   (trig_level),
        .trig_hyst    (trig_hyst),
        .decim        (decim),
        .capture_len  (capture_len),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .triggered    (triggered),
        .done         (done),
        .state        (state),
        .sample_count (sample_count)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [15:0] data;
        logic        trig;
        logic        done;
        int          count;
        int          cyc;
    } rec_t;

    rec_t exp_q[$];
    rec_t obs_q[$];
    logic [7:0] q1[$];
    logic [7:0] q2[$];
    bit rnd1, rnd2;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int bad_state = 0;
    int bad_consec = 0;
    int clk_err = 0;
    logic prev_valid = 1'b0;

    // Reference model state: 0 idle, 1 waiting to prime, 2 armed, 3 capturing.
    bit   mclk, was_tick, pend, fpend;
    logic [15:0] pend_val;
    int   mstate, mcount, tick_idx;
    int   l_src, l_edge, l_level, l_hyst, l_decim, l_len;

    task automatic emit(input logic [15:0] v, input bit trig);
        rec_t r;
        r.data  = v;
        r.trig  = trig;
        r.count = mcount;
        r.done  = (l_len != 0) && (mcount == l_len);
        r.cyc   = cyc;
        exp_q.push_back(r);
        if (r.done) mstate = 0;
    endtask

    task automatic modelSample(input logic [15:0] v);
        int sel, lo, hi;
        bit fire_now;
        sel = l_src ? int'(v[15:8]) : int'(v[7:0]);
        lo = l_level - l_hyst;
        if (lo < 0) lo = 0;
        hi = l_level + l_hyst;
        if (hi > 255) hi = 255;
        fire_now = 1'b0;
        if (mstate == 1) begin
            if (fpend) fire_now = 1'b1;
            else if (l_edge == 0 ? (sel < lo) : (sel > hi)) mstate = 2;
        end else if (mstate == 2) begin
            if (fpend || (l_edge == 0 ? (sel >= l_level) : (sel <= l_level))) fire_now = 1'b1;
        end else if (mstate == 3) begin
            mcount = (mcount + 1) % (1 << LEN_W);
            emit(v, 1'b0);
        end
        if (fire_now) begin
            fpend  = 1'b0;
            mcount = 1;
            mstate = 3;
            emit(v, 1'b1);
        end
    endtask

    always @(posedge sys_clk) begin
        cyc++;
        if (sys_rst) begin
            mclk = 1'b0; mstate = 0; pend = 1'b0; fpend = 1'b0; mcount = 0;
        end else begin
            was_tick = mclk;
            mclk = !mclk;
            if (abort) begin
                mstate = 0; pend = 1'b0; fpend = 1'b0;
            end else begin
                if (force_trig && (mstate == 1 || mstate == 2)) fpend = 1'b1;
                if (pend) begin
                    pend = 1'b0;
                    modelSample(pend_val);
                end
                if (mstate == 0 && arm) begin
                    l_src = int'(trig_src); l_edge = int'(trig_edge);
                    l_level = int'(trig_level); l_hyst = int'(trig_hyst);
                    l_decim = int'(decim); l_len = int'(capture_len);
                    tick_idx = 0; mcount = 0; mstate = 1;
                end else if (was_tick && mstate != 0) begin
                    if (tick_idx % (l_decim + 1) == 0) begin
                        pend = 1'b1;
                        pend_val = {adc_in2, adc_in1};
                    end
                    tick_idx++;
                end
            end
        end
    end

    // Output monitor, sampled on the inactive edge.
    always @(negedge sys_clk) begin
        if (!sys_rst) begin
            if (sample_valid === 1'b1) begin
                rec_t r;
                r.data = sample_data; r.trig = triggered; r.done = done;
                r.count = int'(sample_count); r.cyc = cyc;
                obs_q.push_back(r);
                if (state !== 2'd3) bad_state++;
                if (prev_valid) bad_consec++;
            end
            if (adc_clk !== mclk) clk_err++;
            prev_valid = (sample_valid === 1'b1);
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] expv);
        checks++;
        assert (got === expv) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, got, expv);
        end
    endtask

    task automatic stepCycle();
        @(negedge sys_clk);
        #1;
        arm = 1'b0; abort = 1'b0; force_trig = 1'b0;
        if (mclk) begin
            if (q1.size() > 0) adc_in1 = q1.pop_front();
            else if (rnd1) adc_in1 = 8'($urandom);
            if (q2.size() > 0) adc_in2 = q2.pop_front();
            else if (rnd2) adc_in2 = 8'($urandom);
        end
    endtask

    task automatic runCycles(input int n);
        repeat (n) stepCycle();
    endtask

    task automatic applyStimulus(input bit a, input bit ab, input bit f);
        arm = a; abort = ab; force_trig = f;
    endtask

    task automatic setCfg(input bit src, input bit edg, input logic [7:0] lvl,
                          input logic [7:0] hys, input int dec, input int len);
        trig_src = src; trig_edge = edg; trig_level = lvl; trig_hyst = hys;
        decim = DECIM_W'(dec); capture_len = LEN_W'(len);
        q1.delete(); q2.delete();
    endtask

    task automatic compareQueues(input string tag);
        checkOutput({tag, "_num_samples"}, 64'(obs_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checkOutput($sformatf("%s_data%0d", tag, i), 64'(obs_q[i].data), 64'(exp_q[i].data));
            checkOutput($sformatf("%s_trig%0d", tag, i), 64'(obs_q[i].trig), 64'(exp_q[i].trig));
            checkOutput($sformatf("%s_done%0d", tag, i), 64'(obs_q[i].done), 64'(exp_q[i].done));
            checkOutput($sformatf("%s_count%0d", tag, i), 64'(obs_q[i].count), 64'(exp_q[i].count));
            checkOutput($sformatf("%s_cycle%0d", tag, i), 64'(obs_q[i].cyc), 64'(exp_q[i].cyc));
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        bit exp_clk;
        int ndone;
        sys_rst = 1'b1;
        adc_in1 = 8'h00; adc_in2 = 8'h00;
        arm = 1'b0; abort = 1'b0; force_trig = 1'b0;
        rnd1 = 1'b0; rnd2 = 1'b0;
        setCfg(1'b0, 1'b0, 8'h00, 8'h00, 0, 0);

        $display("[TB] reset");
        repeat (3) @(negedge sys_clk);
        #1;
        checkOutput("rst_adc_clk", 64'(adc_clk), 64'd0);
        checkOutput("rst_state", 64'(state), 64'd0);
        checkOutput("rst_valid", 64'(sample_valid), 64'd0);
        checkOutput("rst_triggered", 64'(triggered), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_count", 64'(sample_count), 64'd0);
        checkOutput("rst_data", 64'(sample_data), 64'd0);
        sys_rst = 1'b0;
        exp_clk = 1'b0;
        for (int i = 0; i < 4; i++) begin
            stepCycle();
            exp_clk = !exp_clk;
            checkOutput($sformatf("adc_clk_toggle%0d", i), 64'(adc_clk), 64'(exp_clk));
        end

        $display("[TB] rising trigger on ch1, len 4");
        setCfg(1'b0, 1'b0, 8'h80, 8'h10, 0, 4);
        applyStimulus(1'b1, 1'b0, 1'b0);
        q1 = '{8'h85, 8'h75, 8'h6F, 8'h90, 8'h91, 8'h92, 8'h93};
        stepCycle();
        trig_level = 8'($urandom);
        capture_len = LEN_W'(1);
        runCycles(30);
        checkOutput("rise_num_valid", 64'(obs_q.size()), 64'd4);
        if (obs_q.size() == 4) begin
            checkOutput("rise_trig_data", 64'(obs_q[0].data[7:0]), 64'h90);
            checkOutput("rise_trig_flag", 64'(obs_q[0].trig), 64'd1);
            checkOutput("rise_spacing", 64'(obs_q[1].cyc - obs_q[0].cyc), 64'd2);
            checkOutput("rise_done_last", 64'(obs_q[3].done), 64'd1);
        end
        checkOutput("rise_count", 64'(sample_count), 64'd4);
        checkOutput("rise_state_idle", 64'(state), 64'd0);
        compareQueues("rise");

        $display("[TB] saturated low threshold, sweep then force");
        setCfg(1'b0, 1'b0, 8'h08, 8'h10, 0, 1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int v = 0; v < 256; v++) q1.push_back(8'(v));
        runCycles(520);
        checkOutput("sat_state_prime", 64'(state), 64'd1);
        checkOutput("sat_no_valid", 64'(obs_q.size()), 64'd0);
        repeat (4) q1.push_back(8'h5A);
        runCycles(6);
        applyStimulus(1'b0, 1'b0, 1'b1);
        runCycles(10);
        checkOutput("force_num_valid", 64'(obs_q.size()), 64'd1);
        if (obs_q.size() == 1) begin
            checkOutput("force_data", 64'(obs_q[0].data[7:0]), 64'h5A);
            checkOutput("force_trig_done", 64'({obs_q[0].trig, obs_q[0].done}), 64'b11);
        end
        checkOutput("force_count", 64'(sample_count), 64'd1);
        checkOutput("force_state_idle", 64'(state), 64'd0);
        compareQueues("force");

        $display("[TB] falling trigger on ch2, decim 2, len 3");
        setCfg(1'b1, 1'b1, 8'h40, 8'h04, 2, 3);
        applyStimulus(1'b1, 1'b0, 1'b0);
        q2 = '{8'h45, 8'h45, 8'h45, 8'h42, 8'h42, 8'h42, 8'h40, 8'h40, 8'h40};
        rnd1 = 1'b1; rnd2 = 1'b1;
        runCycles(60);
        checkOutput("fall_num_valid", 64'(obs_q.size()), 64'd3);
        if (obs_q.size() == 3) begin
            checkOutput("fall_trig_data", 64'(obs_q[0].data[15:8]), 64'h40);
            checkOutput("fall_spacing", 64'(obs_q[2].cyc - obs_q[1].cyc), 64'd6);
        end
        checkOutput("fall_state_idle", 64'(state), 64'd0);
        compareQueues("fall");

        $display("[TB] continuous capture then abort");
        setCfg(1'b0, 1'b0, 8'h80, 8'h10, 0, 0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        q1 = '{8'h60, 8'h90};
        for (int i = 0; i < 100 && exp_q.size() < 10; i++) stepCycle();
        checkOutput("cont_reached_10", 64'(exp_q.size()), 64'd10);
        applyStimulus(1'b0, 1'b1, 1'b0);
        runCycles(2);
        checkOutput("abort_state_idle", 64'(state), 64'd0);
        runCycles(20);
        checkOutput("cont_num_valid", 64'(obs_q.size()), 64'd10);
        ndone = 0;
        foreach (obs_q[i]) if (obs_q[i].done) ndone++;
        checkOutput("cont_no_done", 64'(ndone), 64'd0);
        checkOutput("abort_count_held", 64'(sample_count), 64'd10);
        compareQueues("cont");

        $display("[TB] arm with abort, arm during capture");
        applyStimulus(1'b1, 1'b1, 1'b0);
        stepCycle();
        checkOutput("arm_abort_idle", 64'(state), 64'd0);
        runCycles(4);
        checkOutput("arm_abort_idle_later", 64'(state), 64'd0);
        checkOutput("arm_abort_count", 64'(sample_count), 64'd10);
        setCfg(1'b0, 1'b0, 8'h80, 8'h10, 0, 6);
        applyStimulus(1'b1, 1'b0, 1'b0);
        q1 = '{8'h60, 8'h90};
        for (int i = 0; i < 100 && exp_q.size() < 2; i++) stepCycle();
        applyStimulus(1'b1, 1'b0, 1'b0);
        runCycles(30);
        checkOutput("rearm_num_valid", 64'(obs_q.size()), 64'd6);
        checkOutput("rearm_count", 64'(sample_count), 64'd6);
        compareQueues("rearm");

        $display("[TB] random captures");
        for (int it = 0; it < 8; it++) begin
            setCfg(1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom % 32),
                   int'($urandom % 3), 1 + int'($urandom % 5));
            applyStimulus(1'b1, 1'b0, 1'b0);
            runCycles(10);
            applyStimulus(1'b0, 1'b0, 1'($urandom));
            runCycles(60);
            applyStimulus(1'b0, 1'b1, 1'b0);
            runCycles(3);
            compareQueues($sformatf("rand%0d", it));
        end

        checkOutput("valid_outside_capture", 64'(bad_state), 64'd0);
        checkOutput("consecutive_valid", 64'(bad_consec), 64'd0);
        checkOutput("adc_clk_sequence", 64'(clk_err), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
